mac_pipe_chain: RTL

Parametrised, pipelined chain of configurable MAC stages that replaces the fixed 100-deep combinational `mac_cluster` chain in the fabric top. Each stage holds one registered data slot and a 2-bit mode from a serial configuration chain (PASS, MUL, MAC, ADD). The chain has valid/ready handshaking with backpressure, per-stage saturating accumulators, and a scan-style `config_in`/`config_out` path, so several chains can be daisy-chained in the top level.

---
 rtl/mac_pipe_chain_pkg.sv | 19 +
 rtl/mac_pipe_chain_if.sv | 23 ++
 rtl/mac_pipe_chain_stage.sv | 82 ++++++++
 rtl/mac_pipe_chain.sv | 91 +++++++++
 4 files changed

// File: rtl/mac_pipe_chain_pkg.sv
// Shared types and helpers for the pipelined MAC chain.
// Holds the per-stage mode encoding and the saturation helper.
package mac_pkg;

    typedef enum logic [1:0] {
        PASS = 2'b00,
        MUL  = 2'b01,
        MAC  = 2'b10,
        ADD  = 2'b11
    } mac_mode_t;

    // Clamp an unsigned value to the largest number representable in 'width' bits.
    function automatic logic [63:0] sat_limit(input logic [63:0] value, input int unsigned width);
        logic [63:0] lim;
        lim = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        return (value > lim) ? lim : value;
    endfunction

endpackage

// File: rtl/mac_pipe_chain_if.sv
// Input/output stream handshake bundle of the MAC chain.
interface mac_pipe_chain_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_a;
    logic [WIDTH-1:0] out_b;

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_a, out_b
    );

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_a, out_b
    );
endinterface

// File: rtl/mac_pipe_chain_stage.sv
// One pipeline slot of the MAC chain: registered (valid, a, b) plus a saturating accumulator.
module mac_pipe_stage
    import mac_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned ACC_WIDTH = 2 * WIDTH + 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             adv,
    input  logic             clr,
    input  mac_mode_t        mode,
    input  logic             prev_valid,
    input  logic [WIDTH-1:0] prev_a,
    input  logic [WIDTH-1:0] prev_b,
    output logic             valid,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b
);

    logic                   valid_q;
    logic [WIDTH-1:0]       a_q;
    logic [WIDTH-1:0]       b_q;
    logic [ACC_WIDTH-1:0]   acc_q;
    logic [ACC_WIDTH-1:0]   acc_d;
    logic [ACC_WIDTH-1:0]   acc_base;
    logic [ACC_WIDTH-1:0]   acc_sum;
    logic [2*WIDTH-1:0]     prod;
    logic [WIDTH-1:0]       a_clamp;
    logic [WIDTH-1:0]       a_next;
    logic                   capture;

    assign capture  = adv && prev_valid;
    assign prod     = {{WIDTH{1'b0}}, prev_a} * {{WIDTH{1'b0}}, prev_b};
    // A clear in the same cycle as a capture restarts the sum from this product.
    assign acc_base = clr ? '0 : acc_q;
    assign acc_sum  = ACC_WIDTH'(sat_limit(64'(acc_base) + 64'(prod), ACC_WIDTH));
    assign a_clamp  = WIDTH'(sat_limit(64'(acc_sum), WIDTH));

    always_comb begin
        a_next = prev_a;
        case (mode)
            PASS: a_next = prev_a;
            MUL:  a_next = prod[WIDTH-1:0];
            MAC:  a_next = a_clamp;
            ADD:  a_next = prev_a + prev_b;
        endcase
    end

    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end
        if (capture && (mode == MAC)) begin
            acc_d = acc_sum;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
        end else begin
            acc_q <= acc_d;
            if (adv) begin
                valid_q <= prev_valid;
                if (prev_valid) begin
                    a_q <= a_next;
                    b_q <= prev_b;
                end
            end
        end
    end

    assign valid = valid_q;
    assign a     = a_q;
    assign b     = b_q;

endmodule

// File: rtl/mac_pipe_chain.sv
// Pipelined chain of configurable MAC stages with valid/ready backpressure
// and a daisy-chainable serial configuration path.
module mac_pipe_chain
    import mac_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned STAGES    = 4,
    parameter int unsigned ACC_WIDTH = 2 * WIDTH + 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              config_en,
    input  logic              config_in,
    output logic              config_out,
    input  logic              config_load,
    input  logic              acc_clr,
    mac_pipe_chain_if.slave   bus
);

    localparam int unsigned CFG_W = 2 * STAGES;

    logic [CFG_W-1:0] cfg_sr_q;
    logic [CFG_W-1:0] cfg_sr_d;
    logic [CFG_W-1:0] mode_q;
    logic [CFG_W-1:0] mode_d;
    logic             adv;
    logic             clr_all;

    logic [STAGES:0]  valid_c;
    logic [WIDTH-1:0] a_c [STAGES+1];
    logic [WIDTH-1:0] b_c [STAGES+1];

    assign adv          = !valid_c[STAGES] || bus.out_ready;
    // Intake pauses while configuring; beats already inside keep draining.
    assign bus.in_ready = adv && !config_en && !config_load;
    assign clr_all      = acc_clr || config_load;

    assign valid_c[0] = bus.in_valid && bus.in_ready;
    assign a_c[0]     = bus.in_a;
    assign b_c[0]     = bus.in_b;

    always_comb begin
        cfg_sr_d = cfg_sr_q;
        if (config_en) begin
            cfg_sr_d = {cfg_sr_q[CFG_W-2:0], config_in};
        end
    end

    // Load samples the register before any shift happening in the same cycle.
    always_comb begin
        mode_d = mode_q;
        if (config_load) begin
            mode_d = cfg_sr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_sr_q <= '0;
            mode_q   <= '0;
        end else begin
            cfg_sr_q <= cfg_sr_d;
            mode_q   <= mode_d;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        mac_pipe_stage #(
            .WIDTH     (WIDTH),
            .ACC_WIDTH (ACC_WIDTH)
        ) u_stage (
            .clk        (clk),
            .rst        (rst),
            .adv        (adv),
            .clr        (clr_all),
            .mode       (mac_mode_t'(mode_q[2*k +: 2])),
            .prev_valid (valid_c[k]),
            .prev_a     (a_c[k]),
            .prev_b     (b_c[k]),
            .valid      (valid_c[k+1]),
            .a          (a_c[k+1]),
            .b          (b_c[k+1])
        );
    end

    assign bus.out_valid = valid_c[STAGES];
    assign bus.out_a     = a_c[STAGES];
    assign bus.out_b     = b_c[STAGES];
    assign config_out    = cfg_sr_q[CFG_W-1];

endmodule
